// File: rtl/nano_io_uart_pkg.sv
// Shared constants for the nanoCPU memory-mapped UART: bus region, register
// offsets, STATUS bit positions and serial engine state encodings.
package nano_io_uart_pkg;

    localparam logic [2:0] IO_REGION_DEF = 3'b111;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/nano_uart_tx_shifter.sv
// 8N1 serial engine: state machine, bit timer and shift register.
//   state    | meaning
//   TX_IDLE  | line high, waiting for a byte from the FIFO
//   TX_START | start bit (low) for div+1 clocks
//   TX_DATA  | 8 data bits LSB first, div+1 clocks each
//   TX_STOP  | stop bit (high); may chain straight into the next start bit
module nano_uart_tx_shifter
    import nano_io_uart_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] div,
    input  logic        start,
    input  logic [7:0]  byte_in,
    output logic        txd,
    output logic        busy,
    output logic        ready_for_next
);

    tx_state_e   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        bit_done;

    assign bit_done = (timer_q == 16'd0);

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        txd_d          = 1'b1;
        ready_for_next = 1'b0;
        if (!bit_done) begin
            timer_d = timer_q - 16'd1;
        end
        case (state_q)
            TX_IDLE: begin
                ready_for_next = 1'b1;
                if (start) begin
                    state_d = TX_START;
                    shift_d = byte_in;
                    timer_d = div;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (bit_done) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    timer_d = div;
                end
            end
            TX_DATA: begin
                txd_d = shift_q[0];
                if (bit_done) begin
                    timer_d = div;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                ready_for_next = bit_done;
                if (bit_done) begin
                    if (start) begin
                        state_d = TX_START;
                        shift_d = byte_in;
                        timer_d = div;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // txd is registered from the current state, so the line trails the FSM by one clock
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TX_IDLE;
            timer_q <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != TX_IDLE);

endmodule

// File: rtl/nano_io_uart.sv
// nanoCPU bus responder: register decode, TX FIFO and status, feeding the
// serial engine. Never stalls the CPU; reads are combinational.
module nano_io_uart
    import nano_io_uart_pkg::*;
#(
    parameter logic [2:0]  IO_REGION  = IO_REGION_DEF,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d_address,
    inout  wire  [31:0] d_data,
    input  logic        mem_wr,
    output logic        uart_txd,
    output logic        tx_irq
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;
    logic          sel, wr_en, push, push_ok, pop, full, empty, busy, ready;
    logic [1:0]    reg_off;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign sel     = (d_address[31:29] == IO_REGION);
    assign reg_off = d_address[3:2];
    assign wr_en   = sel && mem_wr;
    assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && (reg_off == REG_TXDATA);
    assign pop     = ready && !empty;
    // a pop in the same cycle frees the slot, so a push on a full FIFO still lands
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        count_d  = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en && (reg_off == REG_STATUS) && d_data[STAT_OVF]) ovf_d = 1'b0;
        if (push && !push_ok) ovf_d = 1'b1;
        if (wr_en && (reg_off == REG_BAUDDIV)) div_d = d_data[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_q[wr_ptr_q] <= d_data[7:0];
    end

    always_comb begin
        rdata = '0;
        case (reg_off)
            REG_STATUS: begin
                rdata[STAT_OVF]   = ovf_q;
                rdata[STAT_EMPTY] = empty;
                rdata[STAT_FULL]  = full;
                rdata[STAT_BUSY]  = busy;
            end
            REG_BAUDDIV: rdata[15:0] = div_q;
            default: ;
        endcase
    end

    assign d_data = (sel && !mem_wr) ? rdata : 32'bz;
    assign tx_irq = empty && !busy;

    assign unused_bits = ^{d_address[28:4], d_address[1:0], d_data[31:16]};

    nano_uart_tx_shifter u_shifter (
        .clock          (clock),
        .reset          (reset),
        .div            (div_q),
        .start          (pop),
        .byte_in        (fifo_q[rd_ptr_q]),
        .txd            (uart_txd),
        .busy           (busy),
        .ready_for_next (ready)
    );

endmodule

// File: tb/tb_nano_io_uart.sv
// Directed bench for nano_io_uart: bus reads/writes plus a serial-line
// scoreboard of expected bits pushed at write time and popped as the line is sampled.
module tb_nano_io_uart;

    localparam logic [31:0] A_TX   = 32'hE000_0000;
    localparam logic [31:0] A_STAT = 32'hE000_0004;
    localparam logic [31:0] A_DIV  = 32'hE000_0008;
    localparam logic [31:0] A_RSV  = 32'hE000_000C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_wr = 1'b0;
    logic        tb_drv = 1'b0;
    logic [31:0] d_address = 32'h0;
    logic [31:0] tb_wdata = 32'h0;
    wire  [31:0] d_data;
    wire         uart_txd;
    wire         tx_irq;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          exp_q[$];
    logic [31:0] rd;

    always #20 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign d_data = tb_drv ? tb_wdata : 32'bz;
    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup pu (d_data[i]);
    end

    nano_io_uart dut (
        .clock     (clock),
        .reset     (reset),
        .d_address (d_address),
        .d_data    (d_data),
        .mem_wr    (mem_wr),
        .uart_txd  (uart_txd),
        .tx_irq    (tx_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge after the commit edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        d_address = addr;
        tb_wdata  = data;
        tb_drv    = 1'b1;
        mem_wr    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        mem_wr    = 1'b0;
        tb_drv    = 1'b0;
        d_address = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        d_address = addr;
        mem_wr    = 1'b0;
        #1;
        data      = d_data;
        d_address = 32'h0;
        #1;
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(1'b1);
    endtask

    // Samples one point per bit; frames after the first must start exactly one bit after the stop sample.
    task automatic watch_frames(input int nfr, input int t, input bit synced, input bit chk_busy,
                                input string tag);
        logic [31:0] st;
        if (!synced) begin
            int w = 0;
            while (uart_txd !== 1'b0 && w < 400) begin
                @(negedge clock);
                w++;
            end
            if (w >= 400) begin
                check({tag, " start timeout"}, {31'b0, uart_txd}, 32'h0);
                return;
            end
        end
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 10; k++) begin
                if (f != 0 || k != 0) repeat (t) @(negedge clock);
                if (exp_q.size() == 0) begin
                    check({tag, " scoreboard empty"}, 32'h1, 32'h0);
                    return;
                end
                check(tag, {31'b0, uart_txd}, {31'b0, exp_q.pop_front()});
                if (chk_busy) begin
                    bus_read(A_STAT, st);
                    check({tag, " busy"}, {31'b0, st[0]}, 32'h1);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lvl_q[$];
        logic any_low;
        int   n1;
        logic [7:0] b56;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst txd", {31'b0, uart_txd}, 32'h1);
        check("rst irq", {31'b0, tx_irq}, 32'h1);
        bus_read(A_STAT, rd);  check("rst status", rd, 32'h4);
        bus_read(A_DIV, rd);   check("rst bauddiv", rd, 32'h3);
        bus_read(32'h6000_0004, rd); check("unselected bus", rd, 32'hFFFF_FFFF);
        bus_read(A_TX, rd);    check("txdata read", rd, 32'h0);
        bus_read(A_RSV, rd);   check("reserved read", rd, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        bus_write(A_DIV, 32'hABCD_0005);
        bus_read(A_DIV, rd);   check("bauddiv rw", rd, 32'h5);
        bus_write(A_DIV, 32'h3);

        // Single byte with latency and busy/irq tracking
        bus_write(A_TX, 32'hA5);
        push_frame(8'hA5);
        check("t2 irq after push", {31'b0, tx_irq}, 32'h0);
        check("t2 txd edge N", {31'b0, uart_txd}, 32'h1);
        @(negedge clock);
        check("t2 txd edge N+1", {31'b0, uart_txd}, 32'h1);
        @(negedge clock);
        watch_frames(1, 4, 1'b1, 1'b1, "t2 bit");
        repeat (4) @(negedge clock);
        check("t2 irq after stop", {31'b0, tx_irq}, 32'h1);
        check("t2 line idle", {31'b0, uart_txd}, 32'h1);

        // Overflow: bytes 1..6 back-to-back, byte 6 dropped
        bus_write(A_TX, 32'h1);
        n1 = cyc;
        for (int i = 2; i <= 6; i++) bus_write(A_TX, 32'(i));
        bus_read(A_STAT, rd);  check("t3 status ovf", rd, 32'hB);
        bus_write(A_STAT, 32'h8);
        bus_read(A_STAT, rd);  check("t3 status cleared", rd, 32'h3);
        while (cyc < n1 + 200) @(negedge clock);
        check("t3 irq before drain", {31'b0, tx_irq}, 32'h0);
        @(negedge clock);
        check("t3 irq after 5 frames", {31'b0, tx_irq}, 32'h1);

        // Back-to-back 00, FF: 20 bit times, no gap
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'hFF);
        push_frame(8'h00);
        push_frame(8'hFF);
        watch_frames(2, 4, 1'b0, 1'b0, "t4 bit");
        repeat (4) @(negedge clock);
        check("t4 idle txd", {31'b0, uart_txd}, 32'h1);
        check("t4 idle irq", {31'b0, tx_irq}, 32'h1);

        // Divisor change during bit 3 (per-clock line trace)
        b56 = 8'h56;
        bus_write(A_TX, 32'h56);
        for (int i = 0; i < 4; i++) lvl_q.push_back(1'b0);
        for (int b = 0; b < 4; b++) for (int i = 0; i < 4; i++) lvl_q.push_back(b56[b]);
        for (int b = 4; b < 8; b++) lvl_q.push_back(b56[b]);
        lvl_q.push_back(1'b1);
        lvl_q.push_back(1'b1);
        begin
            int w = 0;
            while (uart_txd !== 1'b0 && w < 400) begin
                @(negedge clock);
                w++;
            end
            check("t5 start seen", {31'b0, uart_txd}, 32'h0);
        end
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clock);
            check($sformatf("t5 clk %0d", i), {31'b0, uart_txd}, {31'b0, lvl_q.pop_front()});
            if (i == 16) begin
                d_address = A_DIV;
                tb_wdata  = 32'h0;
                tb_drv    = 1'b1;
                mem_wr    = 1'b1;
            end
            if (i == 17) begin
                mem_wr    = 1'b0;
                tb_drv    = 1'b0;
                d_address = 32'h0;
            end
        end
        bus_read(A_STAT, rd);  check("t5 status idle", rd, 32'h4);
        bus_write(A_DIV, 32'h3);

        // Reset mid-frame at data bit 2 with two bytes queued
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h33);
        bus_write(A_TX, 32'h55);
        begin
            int w = 0;
            while (uart_txd !== 1'b0 && w < 400) begin
                @(negedge clock);
                w++;
            end
            check("t6 start seen", {31'b0, uart_txd}, 32'h0);
        end
        repeat (13) @(negedge clock);
        check("t6 bit2 low", {31'b0, uart_txd}, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check("t6 txd after reset", {31'b0, uart_txd}, 32'h1);
        bus_read(A_STAT, rd);  check("t6 status after reset", rd, 32'h4);
        reset = 1'b0;
        any_low = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (uart_txd !== 1'b1) any_low = 1'b1;
        end
        check("t6 no further frames", {31'b0, any_low}, 32'h0);
        check("t6 irq", {31'b0, tx_irq}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
